// File: rtl/reg_native_pkg.sv
// Shared types and constants for the reg_native demultiplexer.
package reg_native_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    localparam logic [1:0] ERR_NONE      = 2'b00;
    localparam logic [1:0] ERR_UNMAPPED  = 2'b01;
    localparam logic [1:0] ERR_MALFORMED = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT   = 2'b11;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

endpackage

// File: rtl/reg_native_addr_dec.sv
// Address decoder: matches the upper address bits against each slave window
// base and reports the lowest-index matching slave.
module reg_native_addr_dec
    import reg_native_pkg::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int N_SLV      = 4,
    parameter int WIN_BITS   = 12,
    parameter int SEL_W      = (N_SLV > 1) ? $clog2(N_SLV) : 1,
    parameter logic [N_SLV*ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
    input  logic [ADDR_WIDTH-1:0] addr_i,
    output logic [SEL_W-1:0]      sel_o,
    output logic                  hit_o
);

    // Scan from the highest index down so the lowest matching index is written last and wins.
    always_comb begin
        hit_o = 1'b0;
        sel_o = '0;
        for (int i = N_SLV - 1; i >= 0; i--) begin
            if (addr_i[ADDR_WIDTH-1:WIN_BITS] ==
                BASE_ADDR[i*ADDR_WIDTH+WIN_BITS +: ADDR_WIDTH-WIN_BITS]) begin
                hit_o = 1'b1;
                sel_o = SEL_W'(i);
            end
        end
    end

endmodule

// File: rtl/reg_native_demux.sv
// One-outstanding-transaction demultiplexer from a single reg_native master to
// N_SLV slaves, with its own error responses for unmapped, malformed and
// timed-out accesses.
module reg_native_demux
    import reg_native_pkg::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 32,
    parameter int N_SLV      = 4,
    parameter int WIN_BITS   = 12,
    parameter logic [N_SLV*ADDR_WIDTH-1:0] BASE_ADDR = '0,
    parameter int TMO_CYCLES = 255,
    parameter logic [DATA_WIDTH-1:0] ERR_DATA = DATA_WIDTH'(ERR_DATA_DEFAULT)
) (
    input  logic                        fsm_clk,
    input  logic                        fsm_rstn,
    input  logic                        soft_rst,
    input  logic                        req_vld,
    input  logic                        wr_en,
    input  logic                        rd_en,
    input  logic [ADDR_WIDTH-1:0]       addr,
    input  logic [DATA_WIDTH-1:0]       wr_data,
    output logic                        ack_vld,
    output logic [DATA_WIDTH-1:0]       rd_data,
    output logic [N_SLV-1:0]            slv_req_vld,
    output logic [N_SLV-1:0]            slv_wr_en,
    output logic [N_SLV-1:0]            slv_rd_en,
    output logic [ADDR_WIDTH-1:0]       slv_addr,
    output logic [DATA_WIDTH-1:0]       slv_wr_data,
    input  logic [N_SLV-1:0]            slv_ack_vld,
    input  logic [N_SLV*DATA_WIDTH-1:0] slv_rd_data,
    output logic                        err_vld,
    output logic [1:0]                  err_code,
    output logic                        busy
);

    localparam int SEL_W = (N_SLV > 1) ? $clog2(N_SLV) : 1;
    localparam logic [15:0] TMO_LAST = 16'(TMO_CYCLES - 1);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  wr_q, wr_d;
    logic                  rd_q, rd_d;
    logic [SEL_W-1:0]      sel_q, sel_d;
    logic [1:0]            err_q, err_d;
    logic [15:0]           cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic [SEL_W-1:0]      decSel;
    logic                  decHit;
    logic                  selAck;
    logic [DATA_WIDTH-1:0] selData;

    reg_native_addr_dec #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .N_SLV      (N_SLV),
        .WIN_BITS   (WIN_BITS),
        .SEL_W      (SEL_W),
        .BASE_ADDR  (BASE_ADDR)
    ) u_addr_dec (
        .addr_i (addr),
        .sel_o  (decSel),
        .hit_o  (decHit)
    );

    assign selAck      = slv_ack_vld[sel_q];
    assign selData     = slv_rd_data[int'(sel_q)*DATA_WIDTH +: DATA_WIDTH];
    assign slv_addr    = addr_q;
    assign slv_wr_data = wdata_q;
    assign rd_data     = rdata_q;

    // State and capture registers; either reset source abandons any transaction in flight.
    always_ff @(posedge fsm_clk) begin
        if (!fsm_rstn || soft_rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            sel_q   <= '0;
            err_q   <= ERR_NONE;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            sel_q   <= sel_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    // Next-state decode plus the per-state output pulses.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wr_d        = wr_q;
        rd_d        = rd_q;
        sel_d       = sel_q;
        err_d       = err_q;
        cnt_d       = cnt_q;
        rdata_d     = rdata_q;
        ack_vld     = 1'b0;
        err_vld     = 1'b0;
        err_code    = ERR_NONE;
        slv_req_vld = '0;
        slv_wr_en   = '0;
        slv_rd_en   = '0;
        busy        = (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                if (req_vld) begin
                    addr_d  = addr;
                    wdata_d = wr_data;
                    wr_d    = wr_en;
                    rd_d    = rd_en;
                    sel_d   = decSel;
                    if (wr_en == rd_en) begin
                        err_d   = ERR_MALFORMED;
                        rdata_d = ERR_DATA;
                        state_d = ST_RESP;
                    end else if (!decHit) begin
                        err_d   = ERR_UNMAPPED;
                        rdata_d = ERR_DATA;
                        state_d = ST_RESP;
                    end else begin
                        err_d   = ERR_NONE;
                        state_d = ST_FWD;
                    end
                end
            end
            ST_FWD: begin
                slv_req_vld[sel_q] = 1'b1;
                slv_wr_en[sel_q]   = wr_q;
                slv_rd_en[sel_q]   = rd_q;
                cnt_d              = '0;
                state_d            = ST_WAIT;
            end
            ST_WAIT: begin
                if (selAck) begin
                    rdata_d = selData;
                    err_d   = ERR_NONE;
                    state_d = ST_RESP;
                end else if (cnt_q == TMO_LAST) begin
                    rdata_d = ERR_DATA;
                    err_d   = ERR_TIMEOUT;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_RESP: begin
                ack_vld  = 1'b1;
                err_vld  = (err_q != ERR_NONE);
                err_code = err_q;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_reg_native_demux.sv
// Directed bench for reg_native_demux: a transaction-level timeline model fills
// per-cycle expected outputs, a compare process checks every cycle, and a set
// of literal checks pins the model at key cycles.
module tb_reg_native_demux;

    localparam int NCYC = 140;
    localparam int ENDC = 130;
    localparam int TMO  = 8;
    localparam logic [255:0] BASE = {64'h3000, 64'h2000, 64'h1000, 64'h0};

    logic         fsm_clk;
    logic         fsm_rstn;
    logic         soft_rst;
    logic         req_vld;
    logic         wr_en;
    logic         rd_en;
    logic [63:0]  addr;
    logic [31:0]  wr_data;
    logic         ack_vld;
    logic [31:0]  rd_data;
    logic [3:0]   slv_req_vld;
    logic [3:0]   slv_wr_en;
    logic [3:0]   slv_rd_en;
    logic [63:0]  slv_addr;
    logic [31:0]  slv_wr_data;
    logic [3:0]   slv_ack_vld;
    logic [127:0] slv_rd_data;
    logic         err_vld;
    logic [1:0]   err_code;
    logic         busy;

    reg_native_demux #(
        .ADDR_WIDTH (64),
        .DATA_WIDTH (32),
        .N_SLV      (4),
        .WIN_BITS   (12),
        .BASE_ADDR  (BASE),
        .TMO_CYCLES (TMO),
        .ERR_DATA   (32'hDEAD_BEEF)
    ) dut (
        .fsm_clk     (fsm_clk),
        .fsm_rstn    (fsm_rstn),
        .soft_rst    (soft_rst),
        .req_vld     (req_vld),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .addr        (addr),
        .wr_data     (wr_data),
        .ack_vld     (ack_vld),
        .rd_data     (rd_data),
        .slv_req_vld (slv_req_vld),
        .slv_wr_en   (slv_wr_en),
        .slv_rd_en   (slv_rd_en),
        .slv_addr    (slv_addr),
        .slv_wr_data (slv_wr_data),
        .slv_ack_vld (slv_ack_vld),
        .slv_rd_data (slv_rd_data),
        .err_vld     (err_vld),
        .err_code    (err_code),
        .busy        (busy)
    );

    // Input schedule, indexed by the cycle during which the value is driven.
    logic         drvReq   [NCYC];
    logic         drvWr    [NCYC];
    logic         drvRd    [NCYC];
    logic [63:0]  drvAddr  [NCYC];
    logic [31:0]  drvWdata [NCYC];
    logic [3:0]   drvAck   [NCYC];
    logic [127:0] drvAckD  [NCYC];
    logic         drvSoft  [NCYC];

    // Expected outputs, indexed by cycle.
    logic         expAck   [NCYC];
    logic         expErr   [NCYC];
    logic [1:0]   expCode  [NCYC];
    logic [31:0]  expRd    [NCYC];
    logic [3:0]   expSReq  [NCYC];
    logic [3:0]   expSWr   [NCYC];
    logic [3:0]   expSRd   [NCYC];
    logic         expBusy  [NCYC];
    logic [63:0]  expSAddr [NCYC];
    logic [31:0]  expSWd   [NCYC];

    logic [63:0] baseTab [4] = '{64'h0, 64'h1000, 64'h2000, 64'h3000};

    int cyc = 0;
    int nCmp = 0;
    int nErr = 0;

    initial begin
        fsm_clk = 1'b0;
        forever #5 fsm_clk = ~fsm_clk;
    end

    always @(posedge fsm_clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nCmp++;
        if (act !== exp) begin
            nErr++;
            $display("[TB] FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    task automatic applyStimulus(input int k);
        fsm_rstn    = (k >= 3);
        soft_rst    = drvSoft[k];
        req_vld     = drvReq[k];
        wr_en       = drvWr[k];
        rd_en       = drvRd[k];
        addr        = drvAddr[k];
        wr_data     = drvWdata[k];
        slv_ack_vld = drvAck[k];
        slv_rd_data = drvAckD[k];
    endtask

    task automatic scheduleAck(input int k, input int s, input logic [31:0] d);
        drvAck[k][s]        = 1'b1;
        drvAckD[k][s*32 +: 32] = d;
    endtask

    // Transaction-level model: decode the request, find the first ack from the
    // chosen slave inside its timeout window, and lay out the resulting timeline.
    task automatic planRequest(input int c, input logic [63:0] a, input logic w, input logic r,
                               input logic [31:0] wd);
        int s;
        bit hit;
        logic [1:0] code;
        int respAt;
        logic [31:0] data;
        drvReq[c] = 1'b1; drvWr[c] = w; drvRd[c] = r; drvAddr[c] = a; drvWdata[c] = wd;
        hit = 0; s = 0;
        for (int i = 0; i < 4; i++)
            if (!hit && a[63:12] == baseTab[i][63:12]) begin hit = 1; s = i; end
        for (int k = c + 1; k < NCYC; k++) begin expSAddr[k] = a; expSWd[k] = wd; end
        code = (w == r) ? 2'b10 : (!hit ? 2'b01 : 2'b00);
        data = 32'hDEAD_BEEF;
        respAt = c + 1;
        if (code == 2'b00) begin
            expSReq[c+1][s] = 1'b1;
            expSWr[c+1][s]  = w;
            expSRd[c+1][s]  = r;
            respAt = -1;
            for (int k = c + 2; k <= c + 1 + TMO; k++)
                if (respAt < 0 && drvAck[k][s]) begin
                    respAt = k + 1;
                    data   = drvAckD[k][s*32 +: 32];
                end
            if (respAt < 0) begin
                respAt = c + 2 + TMO;
                code   = 2'b11;
            end
        end
        for (int k = c + 1; k <= respAt; k++) expBusy[k] = 1'b1;
        expAck[respAt]  = 1'b1;
        expErr[respAt]  = (code != 2'b00);
        expCode[respAt] = code;
        for (int k = respAt; k < NCYC; k++) expRd[k] = data;
    endtask

    task automatic planReset(input int r);
        drvSoft[r] = 1'b1;
        for (int k = r + 1; k < NCYC; k++) begin
            expAck[k] = 0; expErr[k] = 0; expCode[k] = 0; expRd[k] = 0;
            expSReq[k] = 0; expSWr[k] = 0; expSRd[k] = 0; expBusy[k] = 0;
            expSAddr[k] = 0; expSWd[k] = 0;
        end
    endtask

    // Per-cycle compare against the model, then drive the inputs for this cycle.
    always @(negedge fsm_clk) begin
        if (cyc >= 1 && cyc < NCYC) begin
            checkOutput("ack_vld",     64'(ack_vld),     64'(expAck[cyc]));
            checkOutput("err_vld",     64'(err_vld),     64'(expErr[cyc]));
            checkOutput("err_code",    64'(err_code),    64'(expCode[cyc]));
            checkOutput("rd_data",     64'(rd_data),     64'(expRd[cyc]));
            checkOutput("slv_req_vld", 64'(slv_req_vld), 64'(expSReq[cyc]));
            checkOutput("slv_wr_en",   64'(slv_wr_en),   64'(expSWr[cyc]));
            checkOutput("slv_rd_en",   64'(slv_rd_en),   64'(expSRd[cyc]));
            checkOutput("busy",        64'(busy),        64'(expBusy[cyc]));
            checkOutput("slv_addr",    slv_addr,         expSAddr[cyc]);
            checkOutput("slv_wr_data", 64'(slv_wr_data), 64'(expSWd[cyc]));
            if (drvReq[cyc]) checkOutput("req_while_busy", 64'(busy), 64'd0);
            applyStimulus(cyc);
        end
    end

    // Literal check at a known cycle; callers wait for that cycle before sampling.
    task automatic pin(input int t, input string name, input logic [63:0] act_unused, input logic [63:0] exp);
        checkOutput(name, act_unused, exp);
        if (t < 0) $display("[TB] note: negative pin cycle");
    endtask

    task automatic waitCycle(input int t);
        while (cyc < t) @(negedge fsm_clk);
    endtask

    initial begin
        for (int k = 0; k < NCYC; k++) begin
            drvReq[k] = 0; drvWr[k] = 0; drvRd[k] = 0; drvAddr[k] = 0; drvWdata[k] = 0;
            drvAck[k] = 0; drvAckD[k] = 0; drvSoft[k] = 0;
            expAck[k] = 0; expErr[k] = 0; expCode[k] = 0; expRd[k] = 0;
            expSReq[k] = 0; expSWr[k] = 0; expSRd[k] = 0; expBusy[k] = 0;
            expSAddr[k] = 0; expSWd[k] = 0;
        end
        applyStimulus(0);

        // Acks first, then the requests that consume them, in time order.
        scheduleAck(13, 1, 32'h0000_0000);
        planRequest(10, 64'h1004, 1'b1, 1'b0, 32'hA5A5_0001);
        scheduleAck(22, 3, 32'h1234_5678);
        planRequest(20, 64'h3010, 1'b0, 1'b1, 32'h0);
        scheduleAck(32, 0, 32'hBAD0_BAD0);
        scheduleAck(34, 2, 32'h2222_0002);
        planRequest(30, 64'h2008, 1'b0, 1'b1, 32'h0);
        planRequest(40, 64'h9000, 1'b0, 1'b1, 32'h0);
        planRequest(44, 64'h0000, 1'b1, 1'b1, 32'h0);
        planRequest(48, 64'h0000, 1'b0, 1'b0, 32'h0);
        planRequest(52, 64'h9000, 1'b1, 1'b1, 32'h0);
        scheduleAck(72, 2, 32'h7777_7777);
        planRequest(60, 64'h2000, 1'b0, 1'b1, 32'h0);
        scheduleAck(89, 2, 32'h55AA_55AA);
        planRequest(80, 64'h2000, 1'b0, 1'b1, 32'h0);
        scheduleAck(106, 0, 32'h6666_6666);
        planRequest(100, 64'h0040, 1'b0, 1'b1, 32'h0);
        planReset(104);
        scheduleAck(112, 0, 32'h0000_CAFE);
        planRequest(110, 64'h0ABC, 1'b0, 1'b1, 32'h0);

        // Hand-computed literal expectations.
        waitCycle(2);
        pin(2, "rst_busy", 64'(busy), 64'd0);
        pin(2, "rst_rd_data", 64'(rd_data), 64'd0);
        waitCycle(11);
        pin(11, "wr_slv_req", 64'(slv_req_vld), 64'b0010);
        pin(11, "wr_slv_wr_en", 64'(slv_wr_en), 64'b0010);
        pin(11, "wr_slv_addr", slv_addr, 64'h1004);
        pin(11, "wr_slv_wdata", 64'(slv_wr_data), 64'hA5A5_0001);
        waitCycle(13);
        pin(13, "wr_ack_early", 64'(ack_vld), 64'd0);
        waitCycle(14);
        pin(14, "wr_ack", 64'(ack_vld), 64'd1);
        pin(14, "wr_err_vld", 64'(err_vld), 64'd0);
        waitCycle(22);
        pin(22, "rd3_ack_early", 64'(ack_vld), 64'd0);
        waitCycle(23);
        pin(23, "rd3_ack", 64'(ack_vld), 64'd1);
        pin(23, "rd3_data", 64'(rd_data), 64'h1234_5678);
        waitCycle(35);
        pin(35, "rd2_data", 64'(rd_data), 64'h2222_0002);
        waitCycle(41);
        pin(41, "unmapped_ack", 64'(ack_vld), 64'd1);
        pin(41, "unmapped_code", 64'(err_code), 64'd1);
        pin(41, "unmapped_data", 64'(rd_data), 64'hDEAD_BEEF);
        pin(41, "unmapped_no_req", 64'(slv_req_vld), 64'd0);
        waitCycle(45);
        pin(45, "malformed_both", 64'(err_code), 64'd2);
        waitCycle(49);
        pin(49, "malformed_none", 64'(err_code), 64'd2);
        waitCycle(53);
        pin(53, "malformed_prio", 64'(err_code), 64'd2);
        waitCycle(69);
        pin(69, "tmo_still_busy", 64'(busy), 64'd1);
        waitCycle(70);
        pin(70, "tmo_ack", 64'(ack_vld), 64'd1);
        pin(70, "tmo_code", 64'(err_code), 64'd3);
        waitCycle(73);
        pin(73, "late_ack_ignored", 64'(ack_vld), 64'd0);
        waitCycle(90);
        pin(90, "expiry_ack", 64'(ack_vld), 64'd1);
        pin(90, "expiry_err_vld", 64'(err_vld), 64'd0);
        pin(90, "expiry_data", 64'(rd_data), 64'h55AA_55AA);
        waitCycle(105);
        pin(105, "soft_busy", 64'(busy), 64'd0);
        pin(105, "soft_slv_addr", slv_addr, 64'd0);
        pin(105, "soft_rd_data", 64'(rd_data), 64'd0);
        waitCycle(107);
        pin(107, "soft_no_ack", 64'(ack_vld), 64'd0);
        waitCycle(113);
        pin(113, "post_ack", 64'(ack_vld), 64'd1);
        pin(113, "post_data", 64'(rd_data), 64'h0000_CAFE);

        waitCycle(ENDC);
        $display("== %0d vectors applied, %0d miscompares ==", nCmp, nErr);
        $finish;
    end

endmodule
